// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
//   ifq_state_e  - fetch controller state (IFQ_FETCH / IFQ_FLUSH)
//   PC_STEP      - byte increment between sequential instruction words
//   ifq_entry_t  - layout of one queue entry at the default widths;
//                  the queue stores {instr, pc} with the instruction in the upper bits
package ifq_pkg;

  typedef enum logic [0:0] {
    IFQ_FETCH = 1'b0,
    IFQ_FLUSH = 1'b1
  } ifq_state_e;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned IFQ_DATA_W = 32;
  localparam int unsigned IFQ_ADDR_W = 32;

  typedef struct packed {
    logic [IFQ_DATA_W-1:0] instr;
    logic [IFQ_ADDR_W-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous in-order FIFO holding fetched {instr, pc} entries.
// A push and a pop in the same cycle are legal at any occupancy, including
// full. Pops while empty are ignored. Clear empties the queue in one cycle.
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-low reset
//   clear_i  in   drop all entries (wins over push/pop)
//   push_i   in   write data_i at the tail
//   data_i   in   entry to write (WIDTH bits)
//   pop_i    in   remove the head entry
//   data_o   out  head entry (valid when count_o != 0)
//   count_o  out  number of stored entries (0..DEPTH)
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop, isFull, isEmpty;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CW'(DEPTH));
  assign doPop   = pop_i & ~isEmpty;
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign doPush  = push_i & (~isFull | doPop);

  // Storage array; contents need no reset since count_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage in front of the CPU datapath.
// Issues sequential word fetches to a variable-latency instruction memory,
// buffers in-order responses in a queue and presents {instr, pc} to decode.
// A redirect clears the queue, restarts fetch at the new PC and discards the
// responses of fetches that were already in flight.
// Optional feature macro: IFQ_PERF_CNT_EN adds fetch_cnt_o / flush_cnt_o.
// Ports:
//   clk_i            in   clock
//   rst_i            in   synchronous active-low reset
//   mem_req_valid_o  out  fetch request valid
//   mem_req_addr_o   out  fetch word address
//   mem_req_ready_i  in   memory accepts the request
//   mem_rsp_valid_i  in   read data valid (in request order)
//   mem_rsp_data_i   in   read data
//   redirect_i       in   restart fetch at redirect_pc_i
//   redirect_pc_i    in   new PC (low two bits ignored)
//   instr_valid_o    out  queue head valid
//   instr_o          out  queue head instruction
//   instr_pc_o       out  PC of queue head
//   instr_ready_i    in   decode consumes the head
//   fetch_cnt_o      out  request handshakes (IFQ_PERF_CNT_EN only)
//   flush_cnt_o      out  redirects (IFQ_PERF_CNT_EN only)
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  ifq_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       fetchPc_q, fetchPc_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [CW-1:0]           fifoCount;
  logic [CW-1:0]           inFlightNext;
  logic [CW:0]             creditUsed;
  logic                    creditOk;
  logic                    reqValid, reqHs, rspAccept;
  logic                    pushEn, popEn, headValid;
  logic [DATA_W+ADDR_W-1:0] pushEntry, headEntry;

  // Queued entries plus fetches still in memory may never exceed DEPTH,
  // so every response is guaranteed a free queue slot.
  assign creditUsed = {1'b0, fifoCount} + {1'b0, outstanding_q};
  assign creditOk   = (creditUsed < DEPTH_C);

  assign reqHs     = reqValid & mem_req_ready_i;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rspAccept = rst_i & mem_rsp_valid_i & (outstanding_q != '0);
  assign inFlightNext = outstanding_q + CW'(reqHs) - CW'(rspAccept);

  // Responses are kept only in FETCH; a redirect discards the one arriving with it.
  assign pushEn    = rspAccept & (state_q == IFQ_FETCH) & ~redirect_i;
  assign headValid = rst_i & (fifoCount != '0);
  assign popEn     = headValid & instr_ready_i;
  assign pushEntry = {mem_rsp_data_i, fetchPcOfRsp()};

  // PC of the returning instruction: the oldest outstanding fetch address.
  function automatic logic [ADDR_W-1:0] fetchPcOfRsp();
    return fetchPc_q - ADDR_W'(outstanding_q) * ADDR_W'(PC_STEP);
  endfunction

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (pushEn),
    .data_i  (pushEntry),
    .pop_i   (popEn),
    .data_o  (headEntry),
    .count_o (fifoCount)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IFQ_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect wins; FLUSH ends with the last dropped response.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = (inFlightNext != '0) ? IFQ_FLUSH : IFQ_FETCH;
    end else if (state_q == IFQ_FLUSH && rspAccept && drop_q <= CW'(1)) begin
      state_d = IFQ_FETCH;
    end
  end

  // Output logic: requests only in FETCH with a free credit, silent in reset.
  always_comb begin
    reqValid = 1'b0;
    if (rst_i && state_q == IFQ_FETCH && creditOk) begin
      reqValid = 1'b1;
    end
  end

  // Fetch PC, outstanding and drop counters.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = inFlightNext;
    drop_d        = drop_q;
    if (redirect_i) begin
      fetchPc_d = redirect_pc_i & ~ADDR_W'(3);
      drop_d    = inFlightNext;
    end else begin
      if (reqHs) begin
        fetchPc_d = fetchPc_q + ADDR_W'(PC_STEP);
      end
      if (state_q == IFQ_FLUSH && rspAccept) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] fetchCnt_q, flushCnt_q;

  // Event counters; they wrap silently at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetchCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (reqHs)      fetchCnt_q <= fetchCnt_q + 32'd1;
      if (redirect_i) flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetchCnt_q;
  assign flush_cnt_o = flushCnt_q;
`endif

  assign mem_req_valid_o = reqValid;
  assign mem_req_addr_o  = fetchPc_q;
  assign instr_valid_o   = headValid;
  assign instr_o         = headEntry[DATA_W+ADDR_W-1:ADDR_W];
  assign instr_pc_o      = headEntry[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue.
// Two instances share all inputs: dut uses RESET_PC=0, dut2 uses
// RESET_PC=FFFFFFF8 to show address wrap. A small memory model returns
// responses a fixed number of cycles after each accepted request of dut.
module tb_instr_fetch_queue;
  import ifq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        memReqReady, memRspValid, redirect, instrReady;
  logic [31:0] memRspData, redirectPc;

  logic        reqValid, instrValid, reqValid2, instrValid2;
  logic [31:0] reqAddr, instr, instrPc, reqAddr2, instr2, instrPc2;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] fetchCnt, flushCnt, fetchCnt2, flushCnt2;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] reqLog[$], reqLog2[$], popLog[$], popDataLog[$], popLog2[$];
  int          cycle = 0;
  int          memLat = 1;
  int          checks = 0;
  int          failures = 0;
  int          rz;
  logic        sReqValid, sInstrValid;
  logic [31:0] sReqAddr, sReqAddr2;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_valid_o(reqValid), .mem_req_addr_o(reqAddr), .mem_req_ready_i(memReqReady),
    .mem_rsp_valid_i(memRspValid), .mem_rsp_data_i(memRspData),
    .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .instr_valid_o(instrValid), .instr_o(instr), .instr_pc_o(instrPc),
    .instr_ready_i(instrReady)
`ifdef IFQ_PERF_CNT_EN
    , .fetch_cnt_o(fetchCnt), .flush_cnt_o(flushCnt)
`endif
  );

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_valid_o(reqValid2), .mem_req_addr_o(reqAddr2), .mem_req_ready_i(memReqReady),
    .mem_rsp_valid_i(memRspValid), .mem_rsp_data_i(memRspData),
    .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .instr_valid_o(instrValid2), .instr_o(instr2), .instr_pc_o(instrPc2),
    .instr_ready_i(instrReady)
`ifdef IFQ_PERF_CNT_EN
    , .fetch_cnt_o(fetchCnt2), .flush_cnt_o(flushCnt2)
`endif
  );

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic iRdy,
                               input logic redir, input logic [31:0] rpc);
    memRspValid = 1'b0;
    memRspData  = '0;
    if (!rst) begin
      memQ.delete();
    end else if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      memRspValid = 1'b1;
      memRspData  = instrFor(memQ[0].addr);
      void'(memQ.pop_front());
    end
    rst_i       = rst;
    memReqReady = rdy;
    instrReady  = iRdy;
    redirect    = redir;
    redirectPc  = rpc;
    #1;
    sReqValid   = reqValid;
    sInstrValid = instrValid;
    sReqAddr    = reqAddr;
    sReqAddr2   = reqAddr2;
    if (reqValid && memReqReady) begin
      memQ.push_back('{addr: reqAddr, due: cycle + memLat});
      reqLog.push_back(reqAddr);
    end
    if (reqValid2 && memReqReady) reqLog2.push_back(reqAddr2);
    if (instrValid && instrReady) begin
      popLog.push_back(instrPc);
      popDataLog.push_back(instr);
    end
    if (instrValid2 && instrReady) popLog2.push_back(instrPc2);
    @(posedge clk_i);
    @(negedge clk_i);
    cycle++;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("reset req valid", 32'(sReqValid), 32'd0);
    checkOutput("reset instr valid", 32'(sInstrValid), 32'd0);
    reqLog.delete(); reqLog2.delete();
    popLog.delete(); popDataLog.delete(); popLog2.delete();
  endtask

  initial begin
    rst_i = 1'b0; memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
    redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
    @(negedge clk_i);

    // Sequential fetch with a 1-cycle memory; dut2 wraps past 2^32.
    resetDut();
    memLat = 1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("seq req count", 32'(reqLog.size()), 32'd8);
    for (int k = 0; k < 4; k++) checkOutput("seq req addr", reqLog[k], 32'(k * 4));
    checkOutput("seq pop count", 32'(popLog.size()), 32'd6);
    for (int k = 0; k < 3; k++) begin
      checkOutput("seq pop pc", popLog[k], 32'(k * 4));
      checkOutput("seq pop instr", popDataLog[k], instrFor(32'(k * 4)));
    end
    checkOutput("wrap req 0", reqLog2[0], 32'hFFFF_FFF8);
    checkOutput("wrap req 1", reqLog2[1], 32'hFFFF_FFFC);
    checkOutput("wrap req 2", reqLog2[2], 32'h0000_0000);
    checkOutput("wrap pop 0", popLog2[0], 32'hFFFF_FFF8);
    checkOutput("wrap pop 1", popLog2[1], 32'hFFFF_FFFC);
    checkOutput("wrap pop 2", popLog2[2], 32'h0000_0000);

    // Decode stalled: exactly DEPTH requests, then one pop frees one credit.
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("full req count", 32'(reqLog.size()), 32'd4);
    checkOutput("full req valid", 32'(reqValid), 32'd0);
    checkOutput("full head valid", 32'(instrValid), 32'd1);
    checkOutput("full head pc", instrPc, 32'h0);
`ifdef IFQ_PERF_CNT_EN
    checkOutput("fetch cnt", fetchCnt, 32'd4);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("one pop pc", popLog[0], 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("refill req count", 32'(reqLog.size()), 32'd5);
    checkOutput("refill req addr", reqLog[4], 32'h10);
    checkOutput("refill req valid", 32'(reqValid), 32'd0);
    checkOutput("refill head pc", instrPc, 32'h4);

    // Reset with a full queue.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("midrst req valid", 32'(sReqValid), 32'd0);
    checkOutput("midrst instr valid", 32'(sInstrValid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("postrst instr valid", 32'(sInstrValid), 32'd0);
    checkOutput("postrst req valid", 32'(sReqValid), 32'd1);
    checkOutput("postrst req addr", sReqAddr, 32'h0);
    checkOutput("postrst req addr2", sReqAddr2, 32'hFFFF_FFF8);

    // Redirect with two fetches outstanding; both returns must be dropped.
    resetDut();
    memLat = 3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("pre redirect reqs", 32'(reqLog.size()), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h103);
    rz = reqLog.size();
    checkOutput("flush state", 32'(dut.state_q), 32'(IFQ_FLUSH));
    checkOutput("flush req valid", 32'(reqValid), 32'd0);
    checkOutput("flush instr valid", 32'(instrValid), 32'd0);
`ifdef IFQ_PERF_CNT_EN
    checkOutput("flush cnt", flushCnt, 32'd1);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("flush no req", 32'(reqLog.size()), 32'(rz));
    checkOutput("flush done state", 32'(dut.state_q), 32'(IFQ_FETCH));
    checkOutput("flush no pop", 32'(popLog.size()), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("redirect req addr", reqLog[rz], 32'h100);
    checkOutput("redirect pop pc", popLog[0], 32'h100);
    checkOutput("redirect pop instr", popDataLog[0], instrFor(32'h100));

    // Redirect coinciding with a response and a request handshake.
    resetDut();
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    rz = reqLog.size();
    checkOutput("coinc hs addr", reqLog[1], 32'h4);
    checkOutput("coinc state", 32'(dut.state_q), 32'(IFQ_FLUSH));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("coinc done state", 32'(dut.state_q), 32'(IFQ_FETCH));
    checkOutput("coinc instr valid", 32'(instrValid), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("coinc req addr", reqLog[rz], 32'h200);
    checkOutput("coinc pop pc", popLog[0], 32'h200);
    checkOutput("coinc pop instr", popDataLog[0], instrFor(32'h200));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
